// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register for the multi-lane datapath: per-lane write-back slots,
// shared HI/LO write, stall/bubble/flush control and a saturating retire counter.
module wb_stage_reg #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      stall_this,
    input  logic                      stall_next,
    input  logic [LANES-1:0]          mem_valid,
    input  logic [LANES*ADDR_W-1:0]   mem_wd,
    input  logic [LANES-1:0]          mem_wreg,
    input  logic [LANES*DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]         mem_hi,
    input  logic [DATA_W-1:0]         mem_lo,
    input  logic                      mem_whilo,
    output logic [LANES-1:0]          wb_valid,
    output logic [LANES*ADDR_W-1:0]   wb_wd,
    output logic [LANES-1:0]          wb_wreg,
    output logic [LANES*DATA_W-1:0]   wb_wdata,
    output logic [DATA_W-1:0]         wb_hi,
    output logic [DATA_W-1:0]         wb_lo,
    output logic                      wb_whilo,
    output logic [CNT_W-1:0]          retire_cnt
);

    localparam int POP_W = $clog2(LANES + 1);

    logic [LANES-1:0]        r_valid;
    logic [LANES*ADDR_W-1:0] r_wd;
    logic [LANES-1:0]        r_wreg;
    logic [LANES*DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0]       r_hi;
    logic [DATA_W-1:0]       r_lo;
    logic                    r_whilo;
    logic [CNT_W-1:0]        r_cnt;

    logic [LANES*ADDR_W-1:0] w_wd;
    logic [LANES-1:0]        w_wreg;
    logic [LANES*DATA_W-1:0] w_wdata;
    logic [POP_W-1:0]        w_pop;
    logic [CNT_W:0]          w_sum;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_bubble;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic w_younger_hit;

            // A younger lane writing the same register makes this lane's write dead.
            always_comb begin
                w_younger_hit = 1'b0;
                for (int j = gi + 1; j < LANES; j++) begin
                    if (mem_valid[j] && mem_wreg[j] &&
                        (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[gi*ADDR_W +: ADDR_W]))
                        w_younger_hit = 1'b1;
                end
            end

            assign w_wd[gi*ADDR_W +: ADDR_W]    = mem_valid[gi] ? mem_wd[gi*ADDR_W +: ADDR_W] : '0;
            assign w_wdata[gi*DATA_W +: DATA_W] = mem_valid[gi] ? mem_wdata[gi*DATA_W +: DATA_W] : '0;
            assign w_wreg[gi] = mem_valid[gi] && mem_wreg[gi] &&
                                (mem_wd[gi*ADDR_W +: ADDR_W] != '0) && !w_younger_hit;
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++)
            w_pop = w_pop + POP_W'(mem_valid[i]);
    end

    // One extra bit catches the carry so the counter pins at all-ones instead of wrapping.
    assign w_sum      = {1'b0, r_cnt} + (CNT_W+1)'(w_pop);
    assign w_cnt_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_bubble   = flush || (stall_this && !stall_next);

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid <= '0;
            r_wd    <= '0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= 1'b0;
            if (rst)
                r_cnt <= '0;
        end else if (!stall_this) begin
            r_valid <= mem_valid;
            r_wd    <= w_wd;
            r_wreg  <= w_wreg;
            r_wdata <= w_wdata;
            r_hi    <= mem_hi;
            r_lo    <= mem_lo;
            r_whilo <= mem_whilo && (|mem_valid);
            r_cnt   <= w_cnt_next;
        end
    end

    assign wb_valid   = r_valid;
    assign wb_wd      = r_wd;
    assign wb_wreg    = r_wreg;
    assign wb_wdata   = r_wdata;
    assign wb_hi      = r_hi;
    assign wb_lo      = r_lo;
    assign wb_whilo   = r_whilo;
    assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Randomised bench for wb_stage_reg: a rule-level model predicts every output each cycle,
// plus directed scenarios for reset, squash, stalls, flush, HI/LO gating and saturation.
module tb_wb_stage_reg;

    localparam int LANES  = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, flush, stall_this, stall_next;
    logic [LANES-1:0]        mem_valid, mem_wreg;
    logic [LANES*ADDR_W-1:0] mem_wd;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0]       mem_hi, mem_lo;
    logic                    mem_whilo;

    logic [LANES-1:0]        wb_valid, wb_wreg;
    logic [LANES*ADDR_W-1:0] wb_wd;
    logic [LANES*DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0]       wb_hi, wb_lo;
    logic                    wb_whilo;
    logic [31:0]             retire_cnt;

    logic [LANES-1:0]        s_valid, s_wreg;
    logic [LANES*ADDR_W-1:0] s_wd;
    logic [LANES*DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0]       s_hi, s_lo;
    logic                    s_whilo;
    logic [2:0]              s_cnt;

    wb_stage_reg #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_this(stall_this), .stall_next(stall_next),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .retire_cnt(retire_cnt));

    wb_stage_reg #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .stall_this(stall_this), .stall_next(stall_next),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_valid(s_valid), .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_wdata(s_wdata),
        .wb_hi(s_hi), .wb_lo(s_lo), .wb_whilo(s_whilo), .retire_cnt(s_cnt));

    // Expected architectural view of the WB stage.
    logic [LANES-1:0]        e_valid, e_wreg;
    logic [ADDR_W-1:0]       e_wd    [LANES];
    logic [DATA_W-1:0]       e_wdata [LANES];
    logic [DATA_W-1:0]       e_hi, e_lo;
    logic                    e_whilo;
    longint                  e_cnt, e_cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_lane(input int i, input logic v, input logic [ADDR_W-1:0] wd,
                            input logic wr, input logic [DATA_W-1:0] d);
        mem_valid[i] = v;
        mem_wd[i*ADDR_W +: ADDR_W] = wd;
        mem_wreg[i] = wr;
        mem_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_ctl(input logic r, input logic f, input logic st, input logic sn);
        rst = r; flush = f; stall_this = st; stall_next = sn;
    endtask

    function automatic logic [ADDR_W-1:0] in_wd(input int i);
        return mem_wd[i*ADDR_W +: ADDR_W];
    endfunction

    task automatic model();
        int pop;
        bit killed;
        if (rst || flush || (stall_this && !stall_next)) begin
            e_valid = '0; e_wreg = '0; e_hi = '0; e_lo = '0; e_whilo = 1'b0;
            for (int i = 0; i < LANES; i++) begin e_wd[i] = '0; e_wdata[i] = '0; end
            if (rst) begin e_cnt = 0; e_cnt3 = 0; end
        end else if (!stall_this) begin
            pop = 0;
            for (int i = 0; i < LANES; i++) begin
                if (mem_valid[i]) begin
                    pop++;
                    killed = (in_wd(i) == 0);
                    for (int j = i + 1; j < LANES; j++)
                        if (mem_valid[j] && mem_wreg[j] && in_wd(j) == in_wd(i)) killed = 1;
                    e_valid[i] = 1'b1;
                    e_wd[i]    = in_wd(i);
                    e_wdata[i] = mem_wdata[i*DATA_W +: DATA_W];
                    e_wreg[i]  = mem_wreg[i] && !killed;
                end else begin
                    e_valid[i] = 1'b0; e_wd[i] = '0; e_wdata[i] = '0; e_wreg[i] = 1'b0;
                end
            end
            e_hi = mem_hi; e_lo = mem_lo;
            e_whilo = mem_whilo && (pop > 0);
            e_cnt  = (e_cnt + pop > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_cnt + pop;
            e_cnt3 = (e_cnt3 + pop > 7) ? 7 : e_cnt3 + pop;
        end
    endtask

    task automatic compare_all();
        check("valid", wb_valid, e_valid);
        check("wreg",  wb_wreg,  e_wreg);
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("wd%0d", i),    wb_wd[i*ADDR_W +: ADDR_W],    e_wd[i]);
            check($sformatf("wdata%0d", i), wb_wdata[i*DATA_W +: DATA_W], e_wdata[i]);
        end
        check("hi", wb_hi, e_hi);
        check("lo", wb_lo, e_lo);
        check("whilo", wb_whilo, e_whilo);
        check("retire_cnt", retire_cnt, e_cnt);
        check("retire_cnt_sat", s_cnt, e_cnt3);
    endtask

    task automatic cycle();
        model();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < LANES; i++)
            set_lane(i, 1'($urandom), ADDR_W'($urandom_range(0, 7)), 1'($urandom), $urandom);
        mem_hi = $urandom; mem_lo = $urandom; mem_whilo = 1'($urandom);
    endtask

    int sat_seq [5] = '{2, 4, 6, 7, 7};

    initial begin
        e_cnt = 0; e_cnt3 = 0;
        set_ctl(1, 0, 0, 0);
        rand_inputs();

        // Reset with arbitrary inputs, then first real instruction.
        cycle();
        check("rst_valid", wb_valid, 0);
        rand_inputs();
        cycle();
        check("rst_wdata", wb_wdata, 0);
        check("rst_cnt", retire_cnt, 0);
        set_ctl(0, 0, 0, 0);
        set_lane(0, 1, 3, 1, 32'hDEADBEEF);
        set_lane(1, 0, 9, 1, 32'h1234);
        cycle();
        check("first_wdata0", wb_wdata[DATA_W-1:0], 32'hDEADBEEF);
        check("first_cnt", retire_cnt, 1);
        $display("[TB] reset release: wb_wdata0=0x%0h retire_cnt=%0d", wb_wdata[DATA_W-1:0], retire_cnt);

        // Same-destination squash, then $0 squash in the younger lane.
        set_lane(0, 1, 7, 1, 32'hA0A0);
        set_lane(1, 1, 7, 1, 32'hB1B1);
        cycle();
        check("sq_wreg", wb_wreg, 2'b10);
        check("sq_valid", wb_valid, 2'b11);
        check("sq_cnt", retire_cnt, 3);
        set_lane(1, 1, 0, 1, 32'hC2C2);
        cycle();
        check("sq0_wreg", wb_wreg, 2'b01);
        $display("[TB] squash: wb_wreg=%b wb_valid=%b", wb_wreg, wb_valid);

        // Stall matrix: hold x3, bubble, advance.
        set_lane(0, 1, 5, 1, 32'h5555); set_lane(1, 1, 6, 1, 32'h6666);
        cycle();
        set_ctl(0, 0, 1, 1);
        rand_inputs();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold_wdata1", wb_wdata[DATA_W +: DATA_W], 32'h6666);
            $display("[TB] hold %0d: wb_valid=%b cnt=%0d", k, wb_valid, retire_cnt);
        end
        set_ctl(0, 0, 1, 0);
        cycle();
        check("bubble_valid", wb_valid, 0);
        check("bubble_cnt", retire_cnt, 7);
        set_ctl(0, 0, 0, 0);
        rand_inputs();
        cycle();

        // Flush beats stall.
        set_ctl(0, 1, 1, 1);
        set_lane(0, 1, 2, 1, 32'h7777); set_lane(1, 1, 4, 1, 32'h8888);
        cycle();
        check("flush_valid", wb_valid, 0);
        $display("[TB] flush: wb_valid=%b cnt=%0d", wb_valid, retire_cnt);

        // HI/LO gating.
        set_ctl(0, 0, 0, 0);
        mem_valid = '0; mem_whilo = 1; mem_hi = 32'h1111_2222; mem_lo = 32'h3333_4444;
        cycle();
        check("hilo_nv_whilo", wb_whilo, 0);
        check("hilo_nv_hi", wb_hi, 32'h1111_2222);
        mem_valid = 2'b01;
        cycle();
        check("hilo_v_whilo", wb_whilo, 1);
        check("hilo_v_lo", wb_lo, 32'h3333_4444);

        // Saturation on the 3-bit counter instance.
        set_ctl(1, 0, 0, 0);
        cycle();
        set_ctl(0, 0, 0, 0);
        mem_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("sat_seq", s_cnt, 64'(sat_seq[k]));
            $display("[TB] saturation step %0d: retire_cnt=%0d", k, s_cnt);
        end

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            set_ctl($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 2) == 0, 1'($urandom));
            cycle();
            $display("[TB] rand %0d: rst=%0d fl=%0d st=%0d sn=%0d valid=%b wreg=%b cnt=%0d",
                     k, rst, flush, stall_this, stall_next, wb_valid, wb_wreg, retire_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised MEM/WB pipeline register for the multi-lane (superscalar) datapath. It carries LANES independent register write-back slots plus one shared HI/LO write from the memory stage into write-back. The register supports stall-hold, bubble insertion and pipeline flush. Compared with the single-lane stage register it adds:
- per-lane valid bits
- architectural-zero write squashing
- same-destination squashing between lanes
- a saturating retired-instruction counter for performance monitoring

## Interface
Parameters:
- LANES, 2, number of write-back lanes; lane 0 is the oldest instruction, lane LANES-1 the youngest.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width; also the width of HI and LO.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard the incoming MEM contents (exception or branch recovery).
- stall_this  in  1  this stage (MEM/WB) is stalled.
- stall_next  in  1  the write-back consumer is stalled.
- mem_valid  in  LANES  lane carries a real instruction.
- mem_wd  in  LANES*ADDR_W  destination address; lane i occupies bits [i*ADDR_W +: ADDR_W].
- mem_wreg  in  LANES  register write enable, per lane.
- mem_wdata  in  LANES*DATA_W  write data; lane i occupies bits [i*DATA_W +: DATA_W].
- mem_hi, mem_lo  in  DATA_W each  HI/LO write values.
- mem_whilo  in  1  HI/LO write enable.
- wb_valid, wb_wd, wb_wreg, wb_wdata  out  same widths as the matching mem_* inputs  registered lane outputs.
- wb_hi, wb_lo  out  DATA_W each  registered HI/LO values.
- wb_whilo  out  1  registered HI/LO write enable.
- retire_cnt  out  CNT_W  saturating count of valid lanes loaded into WB.

## Operation
Each cycle the block takes exactly one action, chosen by the first condition that holds:
1. **Reset** (rst=1): load the bubble state and set retire_cnt to 0.
2. **Flush** (flush=1): load the bubble state. retire_cnt holds.
3. **Bubble** (stall_this=1, stall_next=0): load the bubble state. retire_cnt holds.
4. **Hold** (stall_this=1, stall_next=1): every output keeps its value.
5. **Advance** (stall_this=0): load the sanitised inputs described below.

Bubble state: all wb_valid=0, all wb_wd=0, all wb_wreg=0, all wb_wdata=0, wb_hi=0, wb_lo=0, wb_whilo=0.

Sanitising on advance, per lane i:
- If mem_valid[i]=0, lane i loads the bubble values: valid=0, wd=0, wreg=0, wdata=0.
- Otherwise the lane loads its inputs, with wreg forced to 0 when either of these holds:
  - mem_wd[i]==0 (writes to register $0 are squashed);
  - some younger lane j>i has mem_valid[j]=1, mem_wreg[j]=1 and mem_wd[j]==mem_wd[i] (the younger lane wins).
- A squashed lane still sets wb_valid=1 and still passes wd and wdata through unchanged.
- wb_whilo=mem_whilo only when at least one mem_valid bit is set; otherwise wb_whilo=0. wb_hi and wb_lo always pass through.

Retire counter, on advance only:
- retire_cnt += popcount(mem_valid), a value between 0 and LANES.
- The sum saturates at 2^CNT_W-1 and never wraps.
- flush, bubble and hold leave it unchanged; only rst clears it.

Simultaneous events:
- flush overrides any stall.
- rst overrides everything, including a transaction mid-hold.

## Timing
- Latency is 1 cycle from mem_* to wb_*. There is no combinational path from inputs to outputs.
- All outputs, including retire_cnt, are driven only from registers.
- A hold may last any number of cycles. The outputs stay bit-stable for its whole duration.
- The bubble state appears in the cycle after the condition that triggers it.
- Every output reads 0 in the cycle after rst is asserted.
- The squash logic compares only lanes presented in the same cycle. There is no cross-cycle comparison.

## Test plan
- **Reset:** drive arbitrary inputs with rst=1 for 2 cycles, then release with stall_this=0 and lane0 = {valid=1, wd=3, wreg=1, wdata=0xDEADBEEF}. Required: every output is 0 during reset; the next cycle shows lane0 values and retire_cnt=1.
- **Same-destination squash:** LANES=2, both lanes valid with wd=7 and wreg=1. Required: wb_wreg=2'b10, wb_valid=2'b11, retire_cnt +2. Repeat with lane1 wd=0: wb_wreg=2'b01.
- **Stall matrix:** load known data, then apply (stall_this, stall_next) = (1,1) for 3 cycles, then (1,0), then (0,0). Required: outputs stable for the 3 hold cycles; bubble state on (1,0); new data on (0,0); retire_cnt unchanged through the hold and bubble.
- **Flush priority:** flush=1 together with stall_this=1, stall_next=1 and valid inputs. Required: bubble state next cycle and retire_cnt unchanged.
- **HI/LO gating:** mem_whilo=1 with mem_valid=0, then with mem_valid=2'b01. Required: wb_whilo=0 in the first case and 1 in the second, with wb_hi and wb_lo passed through in both.
- **Counter saturation:** CNT_W=3, advance with mem_valid=2'b11 for 5 cycles. Required: retire_cnt sequence 2, 4, 6, 7, 7.
